// File: rtl/wb_pkg.sv
// Writeback arbiter shared definitions.
//   req_idx_t : requester index (ALU pipe = 0, load unit = 1)
//   wb_req_t  : writeback request payload at the default register geometry
//   CNT_W     : width of the saturating contention counter
//   other_req : the requester that is not the argument
package wb_pkg;

   localparam int unsigned CNT_W    = 16;
   localparam int unsigned REG_SIZE = 16;
   localparam int unsigned SEL_BITS = 4;
   localparam int unsigned VEC_SIZE = 1;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_idx_t;

   typedef struct packed {
      logic                               isVector;
      logic [SEL_BITS-1:0]                dest;
      logic [VEC_SIZE-1:0][REG_SIZE-1:0]  data;
   } wb_req_t;

   function automatic req_idx_t other_req(input req_idx_t r);
      return (r == REQ_ALU) ? REQ_MEM : REQ_ALU;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a registered priority pointer.
//   clk       : clock, rising edge
//   reset     : synchronous active-high; pointer -> ALU, no grants while high
//   req[1:0]  : request vector, bit 0 = ALU, bit 1 = MEM
//   grant[1:0]: one-hot (or zero) grant, combinational from req and pointer
//   contended : both requests high this cycle (and not in reset)
module rr_arbiter2
   import wb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] grant,
   output logic       contended
);

   req_idx_t ptr_q;
   req_idx_t ptr_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= REQ_ALU;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // The pointer only moves on contention; an uncontested grant leaves it.
   always_comb begin
      grant     = '0;
      ptr_d     = ptr_q;
      contended = 1'b0;
      if (!reset) begin
         contended = &req;
         if (contended) begin
            if (ptr_q == REQ_ALU) begin
               grant = 2'b01;
            end else begin
               grant = 2'b10;
            end
            ptr_d = other_req(ptr_q);
         end else begin
            grant = req;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter between the ALU pipe and the load unit.
// The winning request is captured into a registered write port, so the
// register file sees the write one cycle after the transfer.
//   clk, reset                  : clock; synchronous active-high reset
//   aluValid/memValid           : writeback requests
//   aluReady/memReady           : request accepted this cycle
//   aluIsVector/memIsVector     : 1 = vector destination
//   aluDest/memDest             : destination register number
//   aluData/memData             : write data (scalars use element 0)
//   regWrEnScalar/regWrEnVector : one-cycle write enables
//   regToWrite, dataIn          : write address and data (hold when idle)
//   conflictCount               : saturating count of contended cycles
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned regSize = 16,
   parameter int unsigned selBits = 4,
   parameter int unsigned vecSize = 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             aluValid,
   input  logic                             memValid,
   output logic                             aluReady,
   output logic                             memReady,
   input  logic                             aluIsVector,
   input  logic                             memIsVector,
   input  logic [selBits-1:0]               aluDest,
   input  logic [selBits-1:0]               memDest,
   input  logic [vecSize-1:0][regSize-1:0]  aluData,
   input  logic [vecSize-1:0][regSize-1:0]  memData,
   output logic                             regWrEnScalar,
   output logic                             regWrEnVector,
   output logic [selBits-1:0]               regToWrite,
   output logic [vecSize-1:0][regSize-1:0]  dataIn,
   output logic [CNT_W-1:0]                 conflictCount
);

   // Same fields as wb_req_t, sized by this instance's parameters.
   typedef struct packed {
      logic                             isVector;
      logic [selBits-1:0]               dest;
      logic [vecSize-1:0][regSize-1:0]  data;
   } wr_req_t;

   logic [1:0]       grant;
   logic             contended;
   logic             fire;
   wr_req_t          win;
   logic             wr_scalar_q;
   logic             wr_vector_q;
   logic [CNT_W-1:0] cnt_q;

   rr_arbiter2 u_rr (
      .clk       (clk),
      .reset     (reset),
      .req       ({memValid, aluValid}),
      .grant     (grant),
      .contended (contended)
   );

   assign aluReady = grant[0];
   assign memReady = grant[1];

   // A grant is only ever issued to a valid requester, so any grant is a transfer.
   assign fire = |grant;

   always_comb begin
      win = '0;
      if (grant[0]) begin
         win.isVector = aluIsVector;
         win.dest     = aluDest;
         win.data     = aluData;
      end else if (grant[1]) begin
         win.isVector = memIsVector;
         win.dest     = memDest;
         win.data     = memData;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_scalar_q <= 1'b0;
         wr_vector_q <= 1'b0;
         regToWrite  <= '0;
         dataIn      <= '0;
      end else begin
         wr_scalar_q <= fire & ~win.isVector;
         wr_vector_q <= fire &  win.isVector;
         if (fire) begin
            regToWrite <= win.dest;
            dataIn     <= win.data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (contended && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign conflictCount = cnt_q;

   // A transfer accepted just before reset must not reach the register file
   // during the reset cycle, so the registered enables are masked by reset.
   assign regWrEnScalar = wr_scalar_q & ~reset;
   assign regWrEnVector = wr_vector_q & ~reset;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

   logic              clk = 1'b0;
   logic              reset;
   logic              aluValid, memValid;
   logic              aluReady, memReady;
   logic              aluIsVector, memIsVector;
   logic [3:0]        aluDest, memDest;
   logic [0:0][15:0]  aluData, memData;
   logic              regWrEnScalar, regWrEnVector;
   logic [3:0]        regToWrite;
   logic [0:0][15:0]  dataIn;
   logic [15:0]       conflictCount;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_arbiter #(
      .regSize (16),
      .selBits (4),
      .vecSize (1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .aluValid      (aluValid),
      .memValid      (memValid),
      .aluReady      (aluReady),
      .memReady      (memReady),
      .aluIsVector   (aluIsVector),
      .memIsVector   (memIsVector),
      .aluDest       (aluDest),
      .memDest       (memDest),
      .aluData       (aluData),
      .memData       (memData),
      .regWrEnScalar (regWrEnScalar),
      .regWrEnVector (regWrEnVector),
      .regToWrite    (regToWrite),
      .dataIn        (dataIn),
      .conflictCount (conflictCount)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ready(input string tag, input logic a, input logic m);
      #1;
      chk({tag, "_aluReady"}, 32'(aluReady), 32'(a));
      chk({tag, "_memReady"}, 32'(memReady), 32'(m));
   endtask

   task automatic chk_wr(input string tag, input logic s, input logic v,
                         input logic [3:0] dst, input logic [15:0] dat);
      chk({tag, "_enS"},  32'(regWrEnScalar), 32'(s));
      chk({tag, "_enV"},  32'(regWrEnVector), 32'(v));
      chk({tag, "_dest"}, 32'(regToWrite),    32'(dst));
      chk({tag, "_data"}, 32'(dataIn[0]),     32'(dat));
   endtask

   initial begin
      reset = 1'b1;
      aluValid = 1'b1; memValid = 1'b1;
      aluIsVector = 1'b0; memIsVector = 1'b0;
      aluDest = '0; memDest = '0;
      aluData = '0; memData = '0;

      // Reset state; valids high must not be accepted or counted
      tick; tick;
      chk_ready("rst", 1'b0, 1'b0);
      chk_wr("rst", 1'b0, 1'b0, 4'd0, 16'h0000);
      chk("rst_cnt", 32'(conflictCount), 32'd0);

      aluValid = 1'b0; memValid = 1'b0;
      reset = 1'b0;
      tick;
      chk_wr("idle0", 1'b0, 1'b0, 4'd0, 16'h0000);

      // ALU only, scalar dest 3
      aluValid = 1'b1; aluIsVector = 1'b0; aluDest = 4'd3; aluData = 16'h00AA;
      chk_ready("alu1", 1'b1, 1'b0);
      tick;
      aluValid = 1'b0;
      chk_wr("alu1_wr", 1'b1, 1'b0, 4'd3, 16'h00AA);
      tick;
      chk_wr("alu1_idle", 1'b0, 1'b0, 4'd3, 16'h00AA);

      // Both valid for 4 cycles: ALU, MEM, ALU, MEM
      aluValid = 1'b1; aluIsVector = 1'b0; aluDest = 4'd5; aluData = 16'h0A01;
      memValid = 1'b1; memIsVector = 1'b1; memDest = 4'd6; memData = 16'h0B02;
      chk_ready("rr1", 1'b1, 1'b0);
      tick;
      chk_wr("rr1_wr", 1'b1, 1'b0, 4'd5, 16'h0A01);
      chk_ready("rr2", 1'b0, 1'b1);
      tick;
      chk_wr("rr2_wr", 1'b0, 1'b1, 4'd6, 16'h0B02);
      chk_ready("rr3", 1'b1, 1'b0);
      tick;
      chk_wr("rr3_wr", 1'b1, 1'b0, 4'd5, 16'h0A01);
      chk_ready("rr4", 1'b0, 1'b1);
      tick;
      aluValid = 1'b0; memValid = 1'b0;
      chk_wr("rr4_wr", 1'b0, 1'b1, 4'd6, 16'h0B02);
      chk("rr_cnt", 32'(conflictCount), 32'd4);

      // MEM only, vector dest 1, held 3 cycles
      memValid = 1'b1; memIsVector = 1'b1; memDest = 4'd1; memData = 16'h0C0C;
      chk_ready("mv1", 1'b0, 1'b1);
      tick;
      chk_wr("mv1_wr", 1'b0, 1'b1, 4'd1, 16'h0C0C);
      chk_ready("mv2", 1'b0, 1'b1);
      tick;
      chk_wr("mv2_wr", 1'b0, 1'b1, 4'd1, 16'h0C0C);
      chk_ready("mv3", 1'b0, 1'b1);
      tick;
      memValid = 1'b0;
      chk_wr("mv3_wr", 1'b0, 1'b1, 4'd1, 16'h0C0C);
      tick;
      chk_wr("mv_idle", 1'b0, 1'b0, 4'd1, 16'h0C0C);
      chk("mv_cnt", 32'(conflictCount), 32'd4);

      // Same destination contention: ALU then MEM, MEM value final
      aluValid = 1'b1; aluIsVector = 1'b0; aluDest = 4'd2; aluData = 16'h1111;
      memValid = 1'b1; memIsVector = 1'b0; memDest = 4'd2; memData = 16'h2222;
      chk_ready("sd1", 1'b1, 1'b0);
      tick;
      aluValid = 1'b0;
      chk_wr("sd1_wr", 1'b1, 1'b0, 4'd2, 16'h1111);
      chk_ready("sd2", 1'b0, 1'b1);
      tick;
      memValid = 1'b0;
      chk_wr("sd2_wr", 1'b1, 1'b0, 4'd2, 16'h2222);
      chk("sd_cnt", 32'(conflictCount), 32'd5);
      tick;
      chk_wr("sd_idle", 1'b0, 1'b0, 4'd2, 16'h2222);

      // Reset right after an ALU transfer (pointer currently at MEM)
      aluValid = 1'b1; aluIsVector = 1'b0; aluDest = 4'd7; aluData = 16'h0777;
      chk_ready("ra1", 1'b1, 1'b0);
      tick;
      aluValid = 1'b0;
      reset = 1'b1;
      #1;
      chk("ra_rstcyc_enS", 32'(regWrEnScalar), 32'd0);
      chk("ra_rstcyc_enV", 32'(regWrEnVector), 32'd0);
      tick;
      aluValid = 1'b1; memValid = 1'b1;
      chk_ready("ra_inrst", 1'b0, 1'b0);
      chk_wr("ra_rst", 1'b0, 1'b0, 4'd0, 16'h0000);
      chk("ra_cnt", 32'(conflictCount), 32'd0);
      reset = 1'b0;
      aluDest = 4'd8; aluData = 16'h0808;
      memDest = 4'd9; memData = 16'h0909; memIsVector = 1'b1;
      chk_ready("ra_post", 1'b1, 1'b0);
      tick;
      aluValid = 1'b0; memValid = 1'b0;
      chk_wr("ra_post_wr", 1'b1, 1'b0, 4'd8, 16'h0808);
      chk("ra_post_cnt", 32'(conflictCount), 32'd1);

      // Saturation: drive the counter to FFFE from reset, then 3 more
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("sat_zero", 32'(conflictCount), 32'd0);
      aluValid = 1'b1; memValid = 1'b1;
      repeat (65534) tick;
      chk("sat_fffe", 32'(conflictCount), 32'h0000FFFE);
      tick;
      chk("sat_1", 32'(conflictCount), 32'h0000FFFF);
      tick;
      chk("sat_2", 32'(conflictCount), 32'h0000FFFF);
      tick;
      chk("sat_3", 32'(conflictCount), 32'h0000FFFF);
      aluValid = 1'b0; memValid = 1'b0;
      tick;
      chk("sat_hold", 32'(conflictCount), 32'h0000FFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter regSize, default 16: bits per register element.
REQ-002 Parameter selBits, default 4: register-select width.
REQ-003 Parameter vecSize, default 1: elements per vector register.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 aluValid, memValid  input  1 each  writeback request from ALU pipe (requester 0) and load unit (requester 1).
REQ-007 aluReady, memReady  output  1 each  request accepted this cycle.
REQ-008 aluIsVector, memIsVector  input  1 each  1 = vector destination, 0 = scalar destination.
REQ-009 aluDest, memDest  input  selBits each  destination register number.
REQ-010 aluData, memData  input  vecSize x regSize each  write data; scalars use element 0.
REQ-011 regWrEnScalar, regWrEnVector  output  1 each  register file write enables.
REQ-012 regToWrite  output  selBits  register file write address.
REQ-013 dataIn  output  vecSize x regSize  register file write data.
REQ-014 conflictCount  output  16  count of contended cycles, saturating.

Function
REQ-015 Transfer: the request fires when valid and ready are both high in the same cycle.
REQ-016 Request hold: the requester keeps valid, isVector, dest and data stable until transfer.
REQ-017 Ready timing: ready is combinational from the valid inputs and the priority pointer; at most one ready is high per cycle.
REQ-018 Single requester valid: that requester is granted, whatever the pointer value.
REQ-019 Both valid: the requester named by the priority pointer is granted; the pointer then moves to the other requester.
REQ-020 Pointer hold: a grant with no contention leaves the pointer unchanged; reset sets the pointer to ALU.
REQ-021 Latency: the write port is registered, so outputs reflect a transfer one cycle after it.
- Write enables pulse for exactly one cycle per transfer.
REQ-022 Enable select: on a transfer's write cycle exactly one enable is high.
- regWrEnVector if isVector = 1, else regWrEnScalar.
- Never both.
REQ-023 Idle cycle (no transfer): both enables low; regToWrite and dataIn hold their last values.
REQ-024 Back-to-back: transfers in consecutive cycles give enables on consecutive cycles; throughput is one write per cycle.
REQ-025 Same-destination contention: no special handling; the loser writes later and its value is final.
REQ-026 conflictCount: increments by 1 in every cycle both valids are high.
- Saturates at 16'hFFFF; never wraps.
REQ-027 No combinational path exists from any data/dest input to any output.

Reset
REQ-028 On reset:
- regWrEnScalar, regWrEnVector = 0.
- regToWrite = 0; dataIn = all zeros.
- conflictCount = 0; priority pointer = ALU.
REQ-029 While reset is high, both readies = 0 and no transfer occurs.
REQ-030 Reset mid-operation: a transfer accepted the cycle before reset does not produce a write enable in the reset cycle.

Structure
REQ-031 Package wb_pkg holds:
- requester index enum (REQ_ALU=0, REQ_MEM=1);
- the writeback request struct (isVector, dest, data);
- localparam CNT_W=16.
REQ-032 Sub-module rr_arbiter2 holds the two-way round-robin grant logic and pointer flop; wb_arbiter instantiates it once.

Verification
REQ-033 ALU only, dest=3, scalar, data=16'h00AA -> aluReady same cycle; next cycle regWrEnScalar=1, regToWrite=3, dataIn[0]=16'h00AA, regWrEnVector=0.
REQ-034 Both valid for 4 cycles after reset -> grants ALU, MEM, ALU, MEM; conflictCount=4.
REQ-035 MEM only, vector, dest=1, held 3 cycles -> three consecutive regWrEnVector pulses, each with regToWrite=1.
REQ-036 Both valid with same dest=2, ALU data 16'h1111, MEM data 16'h2222 -> writes in that order; final dataIn[0]=16'h2222 on the second enable cycle.
REQ-037 Reset asserted the cycle after an ALU transfer -> no write enable seen; all outputs zero; next contention grants ALU first.
REQ-038 Force counter to 16'hFFFE, then 3 contended cycles -> conflictCount reads 16'hFFFF and stays there.
